// File: rtl/move_sequencer_if.sv
// Collision-checker handshake between the move sequencer and the board.
// Candidate fields are held from chk_req until chk_done.
interface move_sequencer_if;
  logic       chk_req;
  logic [4:0] chk_type;
  logic [3:0] chk_x;
  logic [4:0] chk_y;
  logic       chk_done;
  logic       chk_hit;

  modport master (
    output chk_req, chk_type, chk_x, chk_y,
    input  chk_done, chk_hit
  );

  modport slave (
    input  chk_req, chk_type, chk_x, chk_y,
    output chk_done, chk_hit
  );
endinterface

// File: rtl/move_sequencer.sv
// Falling-piece move sequencer: latches key/tick pulses, checks one
// candidate move at a time with the board, commits, rejects or locks.
module move_sequencer #(
  parameter logic [3:0] SPAWN_X = 4'd4,
  parameter logic [4:0] SPAWN_Y = 5'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             tick,
  input  logic             rotate,
  input  logic             left,
  input  logic             right,
  input  logic             down,
  input  logic [4:0]       next_type,
  move_sequencer_if.master chk,
  output logic [4:0]       cur_type,
  output logic [3:0]       cur_x,
  output logic [4:0]       cur_y,
  output logic             lock,
  output logic             spawn_ack,
  output logic             game_over
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_READY, S_ISSUE,
    S_WAIT, S_LOCK, S_OVER
  } state_t;

  typedef enum logic [2:0] {
    E_SPAWN, E_TICK, E_ROT,
    E_LEFT, E_RIGHT, E_DOWN
  } evt_t;

  state_t     state, state_n;
  evt_t       evt, evt_n, pick_evt;
  logic [4:0] pend, pend_n;
  logic [4:0] pulse, avail, sel, clr;
  logic [4:0] cand_type;
  logic [3:0] cand_x;
  logic [4:0] cand_y;
  logic       playing, pick, commit;

  assign playing = |mode;
  assign pulse   = {down, right, left, rotate, tick};
  // A pulse in READY is taken the same clk it arrives.
  assign avail   = pend | pulse;
  assign sel     = avail & (~avail + 5'd1);

  always_comb begin
    cand_type = cur_type;
    cand_x    = cur_x;
    cand_y    = cur_y;
    pick_evt  = E_TICK;
    if (|sel) begin
      unique case (1'b1)
        sel[0]: begin
          cand_y   = cur_y + 5'd1;
          pick_evt = E_TICK;
        end
        sel[1]: begin
          cand_type = {cur_type[4:2],
                       cur_type[1:0] + 2'd1};
          pick_evt  = E_ROT;
        end
        sel[2]: begin
          cand_x   = cur_x - 4'd1;
          pick_evt = E_LEFT;
        end
        sel[3]: begin
          cand_x   = cur_x + 4'd1;
          pick_evt = E_RIGHT;
        end
        sel[4]: begin
          cand_y   = cur_y + 5'd1;
          pick_evt = E_DOWN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    evt_n   = evt;
    clr     = '0;
    pick    = 1'b0;
    commit  = 1'b0;
    if (!playing) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  state_n = S_SPAWN;
        S_SPAWN: begin
          state_n = S_ISSUE;
          evt_n   = E_SPAWN;
        end
        S_READY: if (|avail) begin
          state_n = S_ISSUE;
          evt_n   = pick_evt;
          pick    = 1'b1;
          clr     = sel | {sel[0], 4'b0};
        end
        S_ISSUE: state_n = S_WAIT;
        S_WAIT: if (chk.chk_done) begin
          if (!chk.chk_hit) begin
            commit  = (evt != E_SPAWN);
            state_n = S_READY;
          end else if (evt == E_SPAWN) begin
            state_n = S_OVER;
          end else if (evt == E_TICK ||
                       evt == E_DOWN) begin
            state_n = S_LOCK;
          end else begin
            state_n = S_READY;
          end
        end
        S_LOCK:  state_n = S_SPAWN;
        S_OVER:  state_n = S_OVER;
        default: state_n = S_IDLE;
      endcase
    end
    // Consumed flag re-arms only if it was already set.
    for (int i = 0; i < 5; i++) begin
      pend_n[i] = clr[i] ? (pend[i] & pulse[i])
                         : (pend[i] | pulse[i]);
    end
    if (!playing || state == S_OVER) pend_n = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      evt          <= E_SPAWN;
      pend         <= '0;
      chk.chk_req  <= 1'b0;
      chk.chk_type <= '0;
      chk.chk_x    <= '0;
      chk.chk_y    <= '0;
      cur_type     <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      lock         <= 1'b0;
      spawn_ack    <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state       <= state_n;
      evt         <= evt_n;
      pend        <= pend_n;
      chk.chk_req <= playing && state == S_ISSUE;
      spawn_ack   <= playing && state == S_SPAWN;
      lock        <= state_n == S_LOCK;
      game_over   <= state_n == S_OVER;
      if (playing && state == S_SPAWN) begin
        cur_type     <= next_type;
        cur_x        <= SPAWN_X;
        cur_y        <= SPAWN_Y;
        chk.chk_type <= next_type;
        chk.chk_x    <= SPAWN_X;
        chk.chk_y    <= SPAWN_Y;
      end
      if (pick) begin
        chk.chk_type <= cand_type;
        chk.chk_x    <= cand_x;
        chk.chk_y    <= cand_y;
      end
      if (commit) begin
        cur_type <= chk.chk_type;
        cur_x    <= chk.chk_x;
        cur_y    <= chk.chk_y;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: transaction-level piece model, checker
// responder driven from a hit queue, directed key sequences.
module tb_move_sequencer;

  localparam logic [4:0] K_TICK  = 5'b00001;
  localparam logic [4:0] K_ROT   = 5'b00010;
  localparam logic [4:0] K_LEFT  = 5'b00100;
  localparam logic [4:0] K_RIGHT = 5'b01000;
  localparam logic [4:0] K_DOWN  = 5'b10000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       tick = 1'b0, rotate = 1'b0;
  logic       left = 1'b0, right = 1'b0;
  logic       down = 1'b0;
  logic [4:0] next_type = 5'd0;
  logic [4:0] cur_type;
  logic [3:0] cur_x;
  logic [4:0] cur_y;
  logic       lock, spawn_ack, game_over;

  move_sequencer_if chk_bus ();

  move_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .tick      (tick),
    .rotate    (rotate),
    .left      (left),
    .right     (right),
    .down      (down),
    .next_type (next_type),
    .chk       (chk_bus),
    .cur_type  (cur_type),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .lock      (lock),
    .spawn_ack (spawn_ack),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Piece model: committed piece, pending key set, open check
  logic [4:0] m_type = 0;
  logic [3:0] m_x = 0;
  logic [4:0] m_y = 0;
  logic [4:0] m_pend = 0;
  logic       m_wait = 0, m_over = 0, m_off = 1;
  logic       m_spawn_due = 0, m_spawn_loaded = 0;
  logic       m_lock_due = 0;
  int         m_evt = 0;
  logic [4:0] c_type = 0;
  logic [3:0] c_x = 0;
  logic [4:0] c_y = 0;
  int         cyc = 0, t_pulse = -1;
  int         req_cnt = 0, lock_cnt = 0, spawn_cnt = 0;
  logic [4:0] last_type = 0, lock_y = 0;
  logic [3:0] last_x = 0;
  logic [4:0] last_y = 0;
  logic [4:0] keys;
  int         resp_lat = 1;
  logic       hit_q[$];

  function automatic logic quiet();
    return m_pend == 0 && !m_wait &&
           !m_spawn_due && !m_lock_due;
  endfunction

  initial forever begin
    @(negedge clk);
    cyc++;
    if (spawn_ack) begin
      chk("spawn_ack_expected",
          m_spawn_due & ~m_spawn_loaded, 1);
      m_type = next_type;
      m_x = 4'd4;
      m_y = 5'd0;
      m_spawn_loaded = 1;
      spawn_cnt++;
    end
    if (lock) begin
      chk("lock_expected", m_lock_due, 1);
      m_lock_due = 0;
      m_spawn_due = 1;
      lock_cnt++;
      lock_y = cur_y;
    end
    chk("cur_type", cur_type, m_type);
    chk("cur_x", cur_x, m_x);
    chk("cur_y", cur_y, m_y);
    chk("game_over", game_over, m_over);
    if (chk_bus.chk_req) begin
      req_cnt++;
      last_type = chk_bus.chk_type;
      last_x = chk_bus.chk_x;
      last_y = chk_bus.chk_y;
      chk("chk_req_expected",
          !m_wait && (m_spawn_due ? m_spawn_loaded
                                  : m_pend != 0), 1);
      if (!m_wait && m_spawn_due) begin
        c_type = m_type; c_x = m_x; c_y = m_y;
        m_evt = 0;
        m_spawn_due = 0;
        m_spawn_loaded = 0;
        m_wait = 1;
      end else if (!m_wait && m_pend != 0) begin
        c_type = m_type; c_x = m_x; c_y = m_y;
        if (m_pend[0]) begin
          m_evt = 1; c_y = m_y + 5'd1;
          m_pend[0] = 0; m_pend[4] = 0;
        end else if (m_pend[1]) begin
          m_evt = 2;
          c_type = {m_type[4:2], m_type[1:0] + 2'd1};
          m_pend[1] = 0;
        end else if (m_pend[2]) begin
          m_evt = 3; c_x = m_x - 4'd1; m_pend[2] = 0;
        end else if (m_pend[3]) begin
          m_evt = 4; c_x = m_x + 4'd1; m_pend[3] = 0;
        end else begin
          m_evt = 5; c_y = m_y + 5'd1; m_pend[4] = 0;
        end
        if (t_pulse >= 0) chk("req_latency", cyc - t_pulse, 2);
        t_pulse = -1;
        m_wait = 1;
      end
      if (m_wait) begin
        chk("chk_type", chk_bus.chk_type, c_type);
        chk("chk_x", chk_bus.chk_x, c_x);
        chk("chk_y", chk_bus.chk_y, c_y);
      end
    end else if (m_wait) begin
      chk("hold_type", chk_bus.chk_type, c_type);
      chk("hold_x", chk_bus.chk_x, c_x);
      chk("hold_y", chk_bus.chk_y, c_y);
    end
    if (chk_bus.chk_done && m_wait) begin
      m_wait = 0;
      if (!chk_bus.chk_hit) begin
        if (m_evt != 0) begin
          m_type = c_type; m_x = c_x; m_y = c_y;
        end
      end else if (m_evt == 0) begin
        m_over = 1;
      end else if (m_evt == 1 || m_evt == 5) begin
        m_lock_due = 1;
      end
    end
    keys = {down, right, left, rotate, tick};
    if (!rst_n || mode == 2'd0) begin
      if (!rst_n) begin
        m_type = 0; m_x = 0; m_y = 0;
      end
      m_pend = 0; m_wait = 0; m_over = 0;
      m_spawn_due = 0; m_spawn_loaded = 0;
      m_lock_due = 0; m_off = 1; t_pulse = -1;
    end else begin
      if (m_off) begin
        m_off = 0;
        m_spawn_due = 1;
      end
      if (!m_over && keys != 0) begin
        if (quiet()) t_pulse = cyc;
        m_pend = m_pend | keys;
      end
    end
  end

  // Board checker stand-in: answers each request after resp_lat clks
  initial begin
    chk_bus.chk_done = 1'b0;
    chk_bus.chk_hit = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_bus.chk_req) begin
        repeat (resp_lat) @(posedge clk);
        #1;
        chk_bus.chk_done = 1'b1;
        chk_bus.chk_hit = (hit_q.size() > 0) ?
                          hit_q.pop_front() : 1'b0;
        @(posedge clk);
        #1;
        chk_bus.chk_done = 1'b0;
        chk_bus.chk_hit = 1'b0;
      end
    end
  end

  task automatic pulse(input logic [4:0] k);
    @(posedge clk);
    #1;
    {down, right, left, rotate, tick} = k;
    @(posedge clk);
    #1;
    {down, right, left, rotate, tick} = 5'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    repeat (2) @(posedge clk);
    while (!quiet() && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) chk("quiet_timeout", n, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] k, input logic h);
    hit_q.push_back(h);
    pulse(k);
    wait_quiet();
  endtask

  initial begin
    int r;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_chk_req", chk_bus.chk_req, 0);
    chk("rst_lock", lock, 0);
    chk("rst_spawn_ack", spawn_ack, 0);
    chk("rst_chk_fields",
        {chk_bus.chk_type, chk_bus.chk_x, chk_bus.chk_y}, 0);
    chk("rst_cur", {cur_type, cur_x, cur_y}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // spawn at (4,4,0)
    next_type = 5'b00100;
    mode = 2'd1;
    wait_quiet();
    chk("t1_spawn_cnt", spawn_cnt, 1);
    chk("t1_cur", {cur_type, cur_x, cur_y},
        {5'b00100, 4'd4, 5'd0});
    // left accepted, rotate rejected
    resp_lat = 3;
    press(K_LEFT, 1'b0);
    resp_lat = 1;
    chk("t2_chk_x", last_x, 3);
    chk("t2_cur_x", cur_x, 3);
    press(K_ROT, 1'b1);
    chk("t2_rot_cand", last_type, 5'b00101);
    chk("t2_cur_type", cur_type, 5'b00100);
    chk("t2_no_lock", lock_cnt, 0);
    // tick and down together
    repeat (7) press(K_TICK, 1'b0);
    chk("t3_y7", cur_y, 7);
    r = req_cnt;
    press(K_TICK | K_DOWN, 1'b0);
    chk("t3_one_check", req_cnt - r, 1);
    chk("t3_chk_y", last_y, 8);
    chk("t3_cur_y", cur_y, 8);
    // lock at y = 18 then respawn
    repeat (10) press(K_DOWN, 1'b0);
    chk("t4_y18", cur_y, 18);
    next_type = 5'b10001;
    hit_q.push_back(1'b1);
    press(K_TICK, 1'b0);
    chk("t4_lock_cnt", lock_cnt, 1);
    chk("t4_lock_y", lock_y, 18);
    chk("t4_spawn_cnt", spawn_cnt, 2);
    chk("t4_cur", {cur_type, cur_x, cur_y},
        {5'b10001, 4'd4, 5'd0});
    // blocked spawn ends the game
    hit_q.push_back(1'b1);
    press(K_DOWN, 1'b1);
    chk("t5_lock_cnt", lock_cnt, 2);
    chk("t5_game_over", game_over, 1);
    r = req_cnt;
    pulse(K_ROT);
    pulse(K_LEFT);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_no_req", req_cnt - r, 0);
    mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_over_clr", game_over, 0);
    // orientation and x wrap
    next_type = 5'b01011;
    mode = 2'd3;
    wait_quiet();
    chk("t6_spawn_cnt", spawn_cnt, 4);
    press(K_ROT, 1'b0);
    chk("t6_rot_wrap", last_type, 5'b01000);
    chk("t6_cur_type", cur_type, 5'b01000);
    repeat (4) press(K_LEFT, 1'b0);
    chk("t6_x0", cur_x, 0);
    press(K_LEFT, 1'b1);
    chk("t6_x_wrap", last_x, 15);
    chk("t6_cur_x", cur_x, 0);
    // mode drop while waiting on the checker
    resp_lat = 4;
    r = req_cnt;
    pulse(K_RIGHT);
    n = 0;
    while (req_cnt == r && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("t6_req_seen", n < 20, 1);
    #1;
    mode = 2'd0;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_late_done", cur_x, 0);
    chk("t6_late_type", cur_type, 5'b01000);
    resp_lat = 1;
    mode = 2'd1;
    wait_quiet();
    chk("t6_respawn", {cur_type, cur_x, cur_y},
        {5'b01011, 4'd4, 5'd0});
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
